id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter FWD_EN, default 1, SHALL enable operand forwarding when 1; when 0 raw register-file data SHALL be used.
REQ-002 cpu_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 cpu_rst  in  1  reset, synchronous and active-high.
REQ-004 id_valid  in  1  ID slot holds a real instruction.
REQ-005 id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  PC, register-file reads, immediate.
REQ-006 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1 / rs2.
REQ-008 id_alu_op  in  4  ALU operator code, same encoding as the ALU.
REQ-009 id_alua_sel, id_alub_sel  in  1 each  operand A: 0=rs1, 1=pc; operand B: 0=rs2, 1=imm.
REQ-010 id_rf_we, id_mem_we, id_is_load  in  1 each; id_wb_sel  in  2  write-back source.
REQ-011 stall  in  1  hold ID/EX (downstream wait); flush  in  1  kill ID/EX content (branch redirect).
REQ-012 exm_rd, wb_rd  in  5; exm_we, wb_we  in  1; exm_wd, wb_wd  in  32  EX/MEM and MEM/WB write-back tap.
REQ-013 alu_a, alu_b  out  32  ALU operands; alu_op  out  4  registered operator.
REQ-014 ex_valid, ex_rf_we, ex_mem_we, ex_is_load  out  1; ex_wb_sel  out  2; ex_rd  out  5; ex_pc, ex_imm, ex_store_data  out  32.
REQ-015 load_use_hazard  out  1  combinational request for upstream (PC, IF/ID) to hold one cycle.

Function
REQ-016 Stage SHALL be one register level: ID fields captured at cycle N appear on ex_* / ALU outputs in cycle N+1.
REQ-017 Update priority each edge SHALL be: cpu_rst > flush > stall > load_use_hazard > normal load.
REQ-018 flush (including flush with stall) SHALL load a bubble: ex_valid=0, ex_rf_we=0, ex_mem_we=0, ex_is_load=0, ex_rd=0, alu_op=ALU_ADD, all data fields 0.
REQ-019 stall without flush SHALL hold every register unchanged; load_use_hazard SHALL still be computed from held contents.
REQ-020 load_use_hazard SHALL be 1 iff ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_rs1_used & id_rs1_addr==ex_rd) | (id_rs2_used & id_rs2_addr==ex_rd)).
REQ-021 load_use_hazard=1 with stall=0, flush=0 SHALL load a bubble (REQ-018 values); upstream holds, so the dependent instruction enters one cycle later.
REQ-022 Normal load SHALL capture all ID fields; id_valid=0 SHALL force rf_we, mem_we, is_load to 0.
REQ-023 Forwarded rs1 value SHALL be: exm_wd if exm_we & exm_rd!=0 & exm_rd==rs1; else wb_wd if wb_we & wb_rd!=0 & wb_rd==rs1; else registered rs1 data. rs2 identical.
REQ-024 EX/MEM match SHALL take priority over MEM/WB when both match; index 0 SHALL never forward.
REQ-025 alu_a SHALL be ex_pc when alua_sel=1 else forwarded rs1; alu_b SHALL be ex_imm when alub_sel=1 else forwarded rs2.
REQ-026 ex_store_data SHALL be forwarded rs2 regardless of alub_sel.
REQ-027 Forwarding, operand mux, and load_use_hazard SHALL be combinational from registered state and tap inputs, no added cycle.
REQ-028 The stage SHALL NOT write-back-bypass itself; same-cycle register-file write is the register file's responsibility.

Reset
REQ-029 cpu_rst=1 at an edge SHALL load the bubble of REQ-018 regardless of stall/flush; after release, ex_valid=0 until the first normal load.
REQ-030 cpu_rst asserted mid-stall or mid-hazard SHALL clear state; load_use_hazard SHALL read 0 the cycle after reset.

Verification
REQ-031 Pass-through: id_pc=0x100, rs1=5, rs2=7, alub_sel=0, no taps -> next cycle alu_a=5, alu_b=7, ex_valid=1, ex_pc=0x100.
REQ-032 Forward priority: ex rs1_addr=3, exm_rd=3 exm_wd=0xAA, wb_rd=3 wb_wd=0xBB, both we=1 -> alu_a=0xAA; exm_we=0 -> 0xBB; rd=0 -> raw data.
REQ-033 Load-use: lw x5 in EX, ID add rs1=x5 -> load_use_hazard=1, next cycle ex_valid=0, add enters EX the cycle after with hazard=0.
REQ-034 stall=1 for 3 cycles with new ID data -> ex_* and alu_op unchanged; stall+flush -> bubble.
REQ-035 Immediate/PC select: alua_sel=1, alub_sel=1, pc=0x40, imm=0xFFFFFFFC -> alu_a=0x40, alu_b=0xFFFFFFFC, ex_store_data=forwarded rs2.
REQ-036 cpu_rst pulsed while ex holds valid load -> next cycle ex_valid=0, ex_rf_we=0, load_use_hazard=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection; one cycle ID->EX.
// Holds on stall, bubbles on flush/load-use; forwarding, operand mux and hazard are combinational.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [3:0]  id_alu_op,
  input  logic        id_alua_sel,
  input  logic        id_alub_sel,
  input  logic        id_rf_we,
  input  logic        id_mem_we,
  input  logic        id_is_load,
  input  logic [1:0]  id_wb_sel,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  exm_rd,
  input  logic        exm_we,
  input  logic [31:0] exm_wd,
  input  logic [4:0]  wb_rd,
  input  logic        wb_we,
  input  logic [31:0] wb_wd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        ex_valid,
  output logic        ex_rf_we,
  output logic        ex_mem_we,
  output logic        ex_is_load,
  output logic [1:0]  ex_wb_sel,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_store_data,
  output logic        load_use_hazard
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alua_sel;
    logic        alub_sel;
    logic        rf_we;
    logic        mem_we;
    logic        is_load;
    logic [1:0]  wb_sel;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t bubble;
  ex_reg_t capture;
  logic    rs1_hit;
  logic    rs2_hit;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // EX/MEM is younger than MEM/WB, so it wins; x0 is hard-wired and never forwarded.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] raw);
    logic [31:0] val;
    val = raw;
    if (FWD_EN) begin
      if (exm_we && exm_rd != 5'd0 && exm_rd == addr)
        val = exm_wd;
      else if (wb_we && wb_rd != 5'd0 && wb_rd == addr)
        val = wb_wd;
    end
    return val;
  endfunction

  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1_addr == ex_q.rd);
    rs2_hit = id_rs2_used && (id_rs2_addr == ex_q.rd);
    load_use_hazard = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                      id_valid && (rs1_hit || rs2_hit);
  end

  always_comb begin
    bubble        = '0;
    bubble.alu_op = ALU_ADD;

    capture          = '0;
    capture.valid    = id_valid;
    capture.pc       = id_pc;
    capture.imm      = id_imm;
    capture.rs1_data = id_rs1_data;
    capture.rs2_data = id_rs2_data;
    capture.rs1_addr = id_rs1_addr;
    capture.rs2_addr = id_rs2_addr;
    capture.rd       = id_rd_addr;
    capture.alu_op   = id_alu_op;
    capture.alua_sel = id_alua_sel;
    capture.alub_sel = id_alub_sel;
    capture.rf_we    = id_valid && id_rf_we;
    capture.mem_we   = id_valid && id_mem_we;
    capture.is_load  = id_valid && id_is_load;
    capture.wb_sel   = id_wb_sel;
  end

  // Priority: reset > flush > stall > load-use bubble > normal capture.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst || flush)
      ex_q <= bubble;
    else if (stall)
      ex_q <= ex_q;
    else if (load_use_hazard)
      ex_q <= bubble;
    else
      ex_q <= capture;
  end

  always_comb begin
    rs1_fwd       = fwd(ex_q.rs1_addr, ex_q.rs1_data);
    rs2_fwd       = fwd(ex_q.rs2_addr, ex_q.rs2_data);
    alu_a         = ex_q.alua_sel ? ex_q.pc  : rs1_fwd;
    alu_b         = ex_q.alub_sel ? ex_q.imm : rs2_fwd;
    ex_store_data = rs2_fwd;
    alu_op        = ex_q.alu_op;
    ex_valid      = ex_q.valid;
    ex_rf_we      = ex_q.rf_we;
    ex_mem_we     = ex_q.mem_we;
    ex_is_load    = ex_q.is_load;
    ex_wb_sel     = ex_q.wb_sel;
    ex_rd         = ex_q.rd;
    ex_pc         = ex_q.pc;
    ex_imm        = ex_q.imm;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each cycle's outputs.
module tb_id_ex_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used;
  logic [3:0]  id_alu_op;
  logic        id_alua_sel, id_alub_sel;
  logic        id_rf_we, id_mem_we, id_is_load;
  logic [1:0]  id_wb_sel;
  logic        stall, flush;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_we, wb_we;
  logic [31:0] exm_wd, wb_wd;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_rf_we, ex_mem_we, ex_is_load;
  logic [1:0]  ex_wb_sel;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_imm, ex_store_data;
  logic        load_use_hazard;

  id_ex_stage #(.FWD_EN(1'b1)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_alu_op(id_alu_op),
    .id_alua_sel(id_alua_sel), .id_alub_sel(id_alub_sel),
    .id_rf_we(id_rf_we), .id_mem_we(id_mem_we), .id_is_load(id_is_load),
    .id_wb_sel(id_wb_sel), .stall(stall), .flush(flush),
    .exm_rd(exm_rd), .exm_we(exm_we), .exm_wd(exm_wd),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_mem_we(ex_mem_we),
    .ex_is_load(ex_is_load), .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, r1, r2;
    logic [4:0]  a1, a2, rd;
    logic [3:0]  op;
    logic        asel, bsel, rfwe, memwe, ld;
    logic [1:0]  wbs;
  } mst_t;

  typedef struct packed {
    logic [31:0] alu_a, alu_b, pc, imm, store;
    logic [3:0]  op;
    logic        valid, rfwe, memwe, ld, haz;
    logic [1:0]  wbs;
    logic [4:0]  rd;
  } exp_t;

  mst_t m;
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic m_hazard();
    return m.valid && m.ld && (m.rd != 5'd0) && id_valid &&
           ((id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd));
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] raw);
    if (exm_we && exm_rd != 5'd0 && exm_rd == a) return exm_wd;
    if (wb_we && wb_rd != 5'd0 && wb_rd == a) return wb_wd;
    return raw;
  endfunction

  // Bubble is all-zero: ALU_ADD is encoded as 0.
  task automatic model_edge();
    if (cpu_rst || flush) m = '0;
    else if (stall) m = m;
    else if (m_hazard()) m = '0;
    else begin
      m.valid = id_valid;  m.pc = id_pc;  m.imm = id_imm;
      m.r1 = id_rs1_data;  m.r2 = id_rs2_data;
      m.a1 = id_rs1_addr;  m.a2 = id_rs2_addr;  m.rd = id_rd_addr;
      m.op = id_alu_op;    m.asel = id_alua_sel; m.bsel = id_alub_sel;
      m.rfwe = id_valid & id_rf_we; m.memwe = id_valid & id_mem_we;
      m.ld = id_valid & id_is_load; m.wbs = id_wb_sel;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.alu_a = m.asel ? m.pc  : m_fwd(m.a1, m.r1);
    e.alu_b = m.bsel ? m.imm : m_fwd(m.a2, m.r2);
    e.store = m_fwd(m.a2, m.r2);
    e.pc = m.pc; e.imm = m.imm; e.op = m.op; e.valid = m.valid;
    e.rfwe = m.rfwe; e.memwe = m.memwe; e.ld = m.ld; e.wbs = m.wbs; e.rd = m.rd;
    e.haz = m_hazard();
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".alu_a"}, alu_a, e.alu_a);
    check({tag, ".alu_b"}, alu_b, e.alu_b);
    check({tag, ".store"}, ex_store_data, e.store);
    check({tag, ".pc"}, ex_pc, e.pc);
    check({tag, ".imm"}, ex_imm, e.imm);
    check({tag, ".op"}, {28'd0, alu_op}, {28'd0, e.op});
    check({tag, ".ctl"}, {24'd0, ex_valid, ex_rf_we, ex_mem_we, ex_is_load, ex_wb_sel, 2'd0},
          {24'd0, e.valid, e.rfwe, e.memwe, e.ld, e.wbs, 2'd0});
    check({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    check({tag, ".haz"}, {31'd0, load_use_hazard}, {31'd0, e.haz});
  endtask

  task automatic step(input string tag);
    model_edge();
    exp_q.push_back(predict());
    @(posedge cpu_clk);
    #1;
    compare_out(tag);
  endtask

  task automatic probe(input string tag);
    #1;
    exp_q.push_back(predict());
    compare_out(tag);
  endtask

  task automatic id_instr(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                          input logic [31:0] r1, input logic [4:0] a2, input logic [31:0] r2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic ld);
    id_valid = v; id_pc = pc; id_rs1_addr = a1; id_rs1_data = r1;
    id_rs2_addr = a2; id_rs2_data = r2; id_rd_addr = rd; id_imm = imm;
    id_rs1_used = 1'b1; id_rs2_used = !ld; id_is_load = ld;
    id_alu_op = ld ? 4'd0 : 4'd3; id_alua_sel = 1'b0; id_alub_sel = ld;
    id_rf_we = 1'b1; id_mem_we = 1'b0; id_wb_sel = ld ? 2'd1 : 2'd0;
  endtask

  task automatic taps_off();
    exm_rd = 0; exm_we = 0; exm_wd = 0; wb_rd = 0; wb_we = 0; wb_wd = 0;
  endtask

  initial begin
    m = '0;
    cpu_rst = 1'b1; stall = 1'b0; flush = 1'b0;
    taps_off();
    id_instr(1'b1, 32'h3C, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 32'h0, 1'b0);
    stall = 1'b1;
    step("reset");
    check("reset_valid", {31'd0, ex_valid}, 32'd0);
    stall = 1'b0;
    step("reset_hold");
    cpu_rst = 1'b0;

    // Pass-through
    id_instr(1'b1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 1'b0);
    step("pass");
    check("pass_alu_a", alu_a, 32'd5);
    check("pass_alu_b", alu_b, 32'd7);
    check("pass_pc", ex_pc, 32'h100);

    // Forwarding priority on rs1=x3
    id_instr(1'b1, 32'h104, 5'd3, 32'h11, 5'd4, 32'h22, 5'd8, 32'h0, 1'b0);
    step("fwd_load");
    exm_rd = 5'd3; exm_wd = 32'hAA; exm_we = 1'b1;
    wb_rd = 5'd3; wb_wd = 32'hBB; wb_we = 1'b1;
    probe("fwd_both");
    check("fwd_exm", alu_a, 32'hAA);
    exm_we = 1'b0;
    probe("fwd_wb");
    check("fwd_wb_val", alu_a, 32'hBB);
    exm_we = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    probe("fwd_x0");
    check("fwd_raw", alu_a, 32'h11);
    wb_rd = 5'd4; exm_rd = 5'd4;
    probe("fwd_rs2");
    check("fwd_store", ex_store_data, 32'hAA);
    taps_off();

    // Load-use: lw x5 then add using x5
    id_instr(1'b1, 32'h200, 5'd2, 32'h10, 5'd0, 32'h0, 5'd5, 32'h4, 1'b1);
    step("lw");
    id_instr(1'b1, 32'h204, 5'd5, 32'h99, 5'd6, 32'h3, 5'd7, 32'h0, 1'b0);
    probe("lu_detect");
    check("lu_haz", {31'd0, load_use_hazard}, 32'd1);
    step("lu_bubble");
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    step("lu_enter");
    check("lu_add_pc", ex_pc, 32'h204);
    check("lu_add_haz", {31'd0, load_use_hazard}, 32'd0);

    // Stall holds for three cycles while ID changes
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_instr(1'b1, 32'h300 + i, 5'(i), $urandom, 5'(i + 1), $urandom, 5'd9, $urandom, 1'b0);
      id_alu_op = 4'hF;
      step("stall");
    end
    check("stall_pc", ex_pc, 32'h204);
    check("stall_op", {28'd0, alu_op}, 32'd3);

    // Held load keeps reporting the hazard during stall
    stall = 1'b0;
    id_instr(1'b1, 32'h400, 5'd1, 32'h0, 5'd0, 32'h0, 5'd6, 32'h8, 1'b1);
    step("lw2");
    id_instr(1'b1, 32'h404, 5'd1, 32'h0, 5'd6, 32'h5, 5'd7, 32'h0, 1'b0);
    stall = 1'b1;
    step("stall_haz");
    check("stall_haz_val", {31'd0, load_use_hazard}, 32'd1);
    flush = 1'b1;
    step("stall_flush");
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // PC/immediate select with forwarded store data
    id_instr(1'b1, 32'h40, 5'd1, 32'h5, 5'd6, 32'h1234, 5'd2, 32'hFFFFFFFC, 1'b0);
    id_alua_sel = 1'b1; id_alub_sel = 1'b1; id_mem_we = 1'b1;
    wb_rd = 5'd6; wb_we = 1'b1; wb_wd = 32'h77;
    step("imm_sel");
    check("imm_alu_a", alu_a, 32'h40);
    check("imm_alu_b", alu_b, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'h77);
    taps_off();

    // Reset while a load sits in EX with a dependent in ID
    id_instr(1'b1, 32'h500, 5'd1, 32'h0, 5'd0, 32'h0, 5'd5, 32'h0, 1'b1);
    step("lw3");
    id_instr(1'b1, 32'h504, 5'd5, 32'h0, 5'd5, 32'h0, 5'd7, 32'h0, 1'b0);
    cpu_rst = 1'b1; stall = 1'b1;
    step("rst_mid");
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_rfwe", {31'd0, ex_rf_we}, 32'd0);
    check("rst_haz", {31'd0, load_use_hazard}, 32'd0);
    cpu_rst = 1'b0; stall = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_alu_op = 4'($urandom); id_alua_sel = 1'($urandom); id_alub_sel = 1'($urandom);
      id_rf_we = 1'($urandom); id_mem_we = 1'($urandom); id_is_load = 1'($urandom);
      id_wb_sel = 2'($urandom);
      exm_rd = 5'($urandom_range(0, 7)); exm_we = 1'($urandom); exm_wd = $urandom;
      wb_rd = 5'($urandom_range(0, 7)); wb_we = 1'($urandom); wb_wd = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      cpu_rst = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
